// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the I2C register-access initiator.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    IDLE, START, TXBYTE, RXACK, RSTART, RXBYTE, TXNACK, STOP, DONE
  } state_e;

  // Which byte of the transaction the shifter is currently carrying.
  typedef enum logic [1:0] {
    BYTE_DEV_W, BYTE_REG, BYTE_DATA, BYTE_DEV_R
  } byte_e;

  localparam int unsigned QUARTERS_PER_SLOT = 4;
  localparam int unsigned BITS_PER_BYTE     = 8;
  localparam logic        ACK               = 1'b0;
  localparam logic        NACK              = 1'b1;
  localparam logic [6:0]  DEFAULT_DEV_ADDR  = 7'h3C;

endpackage

// File: rtl/i2c_reg_master_if.sv
// Request/response and open-drain bus signals of i2c_reg_master.
interface i2c_reg_master_if;
  logic       start;
  logic       rw;
  logic [7:0] regAddr;
  logic [7:0] wrData;
  logic       busy;
  logic       done;
  logic       ackErr;
  logic [7:0] rdData;
  logic       sclOut;
  logic       sdaOut;
  logic       sclIn;
  logic       sdaIn;

  modport master (
    input  start, rw, regAddr, wrData, sclIn, sdaIn,
    output busy, done, ackErr, rdData, sclOut, sdaOut
  );

  modport slave (
    output start, rw, regAddr, wrData, sclIn, sdaIn,
    input  busy, done, ackErr, rdData, sclOut, sdaOut
  );
endinterface

// File: rtl/i2c_quarter_timer.sv
// Divides clk into SCL quarter periods; tick marks the last cycle of a quarter.
module i2c_quarter_timer
  import i2c_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       scl_held,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int unsigned   CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [1:0]    Q_LAST   = 2'(QUARTERS_PER_SLOT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic          hold;

  // The first Q1 cycle is skipped so sclIn has seen our own registered release.
  always_comb begin
    hold      = scl_held && (quarter_q == 2'd1) && (cnt_q != '0);
    tick      = en && !hold && (cnt_q == CNT_LAST);
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    if (!en) begin
      cnt_d     = '0;
      quarter_d = '0;
    end else if (!hold) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        quarter_d = (quarter_q == Q_LAST) ? 2'd0 : quarter_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

  assign quarter = quarter_q;

endmodule

// File: rtl/i2c_reg_master.sv
// Single-byte I2C register write/read initiator.
// Optional clock stretching support: define I2C_MASTER_STRETCH_EN.
module i2c_reg_master
  import i2c_master_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [6:0]  DEV_ADDR = DEFAULT_DEV_ADDR
) (
  input logic              clk,
  input logic              rst,
  i2c_reg_master_if.master bus
);

  state_e     state_q, state_d;
  byte_e      byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_q, reg_d, wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic       rw_q, rw_d, samp_q, samp_d, ack_err_q, ack_err_d;
  logic       busy_q, busy_d, done_q, done_d, scl_q, scl_d, sda_q, sda_d;
  logic       tick, slot_end, sample, timer_en, scl_held;
  logic [1:0] quarter;

`ifdef I2C_MASTER_STRETCH_EN
  assign scl_held = !bus.sclIn;
`else
  assign scl_held = 1'b0;
`endif

  assign timer_en = (state_q != IDLE) && (state_q != DONE);

  i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (timer_en),
    .scl_held (scl_held),
    .tick     (tick),
    .quarter  (quarter)
  );

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    rw_d      = rw_q;
    samp_d    = samp_q;
    ack_err_d = ack_err_q;
    slot_end  = tick && (quarter == 2'd3);
    sample    = tick && (quarter == 2'd1);
    case (state_q)
      IDLE: if (bus.start) begin
        rw_d      = bus.rw;
        reg_d     = bus.regAddr;
        wdata_d   = bus.wrData;
        shift_d   = {DEV_ADDR, 1'b0};
        byte_d    = BYTE_DEV_W;
        ack_err_d = 1'b0;
        state_d   = START;
      end
      START, RSTART: if (slot_end) begin
        bit_d   = 3'(BITS_PER_BYTE - 1);
        state_d = TXBYTE;
      end
      TXBYTE: if (slot_end) begin
        shift_d = {shift_q[6:0], 1'b0};
        bit_d   = bit_q - 3'd1;
        if (bit_q == 3'd0) state_d = RXACK;
      end
      RXACK: begin
        if (sample) samp_d = bus.sdaIn;
        if (slot_end) begin
          bit_d = 3'(BITS_PER_BYTE - 1);
          if (samp_q == NACK) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else begin
            case (byte_q)
              BYTE_DEV_W: begin
                byte_d  = BYTE_REG;
                shift_d = reg_q;
                state_d = TXBYTE;
              end
              BYTE_REG: if (rw_q) begin
                byte_d  = BYTE_DEV_R;
                shift_d = {DEV_ADDR, 1'b1};
                state_d = RSTART;
              end else begin
                byte_d  = BYTE_DATA;
                shift_d = wdata_q;
                state_d = TXBYTE;
              end
              BYTE_DATA:  state_d = STOP;
              default:    state_d = RXBYTE;
            endcase
          end
        end
      end
      RXBYTE: begin
        if (sample) shift_d = {shift_q[6:0], bus.sdaIn};
        if (slot_end) begin
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) state_d = TXNACK;
        end
      end
      TXNACK: if (slot_end) begin
        rd_data_d = shift_q;
        state_d   = STOP;
      end
      STOP:    if (slot_end) state_d = DONE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // Bus levels follow the current slot/quarter one cycle later through the output flops.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_q)
      START, RSTART: begin
        scl_d = !((quarter == 2'd3) || ((state_q == RSTART) && (quarter == 2'd0)));
        sda_d = (quarter < 2'd2);
      end
      TXBYTE: begin
        scl_d = (quarter == 2'd1) || (quarter == 2'd2);
        sda_d = shift_q[7];
      end
      RXACK, RXBYTE, TXNACK: scl_d = (quarter == 2'd1) || (quarter == 2'd2);
      STOP: begin
        scl_d = (quarter != 2'd0);
        sda_d = (quarter >= 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      byte_q    <= BYTE_DEV_W;
      bit_q     <= '0;
      shift_q   <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rw_q      <= 1'b0;
      samp_q    <= 1'b1;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      rw_q      <= rw_d;
      samp_q    <= samp_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ackErr = ack_err_q;
  assign bus.rdData = rd_data_q;
  assign bus.sclOut = scl_q;
  assign bus.sdaOut = sda_q;

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: protocol-level I2C responder plus transaction reference model.
module tb_i2c_reg_master;
  import i2c_master_pkg::*;

  localparam int unsigned CD      = 4;
  localparam int          STRETCH = 50;
  localparam logic [7:0]  DEVW    = 8'h78;
  localparam logic [7:0]  DEVR    = 8'h79;
  localparam int          EV_S    = -1;
  localparam int          EV_P    = -2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slv_sda = 1'b1;
  logic slv_scl = 1'b1;

  i2c_reg_master_if bus ();

  i2c_reg_master #(.CLK_DIV(CD), .DEV_ADDR(7'h3C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.sdaIn = bus.sdaOut & slv_sda;
  assign bus.sclIn = bus.sclOut & slv_scl;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- responder model (bench configuration is read-only here)
  int         nack_idx    = -1;
  int         stretch_idx = -1;
  logic [7:0] slv_rd      = 8'h00;
  int         events[$];
  int         mode = 0, bitn = 0, rx_idx = 0, frame_byte = 0, stretch_cnt = 0;
  logic [7:0] sh = 8'h00;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, acked = 1'b0, l_scl, l_sda;

  always @(negedge clk) begin
    l_scl = bus.sclIn;
    l_sda = bus.sdaIn;
    if (rst) begin
      mode = 0; slv_sda = 1'b1; slv_scl = 1'b1; stretch_cnt = 0;
    end else begin
      if (!slv_scl && bus.sclOut) begin
        stretch_cnt++;
        if (stretch_cnt > STRETCH) slv_scl = 1'b1;
      end
      if (prev_scl && l_scl && prev_sda && !l_sda) begin
        events.push_back(EV_S);
        if (mode == 0) rx_idx = 0;
        mode = 1; bitn = 0; frame_byte = 0;
      end else if (prev_scl && l_scl && !prev_sda && l_sda) begin
        events.push_back(EV_P);
        mode = 0; slv_sda = 1'b1;
      end else if (!prev_scl && l_scl) begin
        if (mode == 1) begin
          sh = {sh[6:0], l_sda}; bitn++;
        end else if (mode == 4) begin
          events.push_back(256 + int'(l_sda)); mode = 0;
        end
      end else if (prev_scl && !l_scl) begin
        case (mode)
          1: if (bitn == 8) begin
            events.push_back(int'(sh));
            acked   = (rx_idx != nack_idx);
            slv_sda = !acked;
            if (rx_idx == stretch_idx) begin slv_scl = 1'b0; stretch_cnt = 0; end
            mode = 2;
          end
          2: begin
            slv_sda = 1'b1;
            if (acked && frame_byte == 0 && sh[0]) begin
              mode = 3; bitn = 0; slv_sda = slv_rd[7];
            end else begin
              mode = 1; bitn = 0;
            end
            frame_byte++; rx_idx++;
          end
          3: begin
            bitn++;
            if (bitn == 8) begin slv_sda = 1'b1; mode = 4; end
            else slv_sda = slv_rd[7-bitn];
          end
          default: ;
        endcase
      end
    end
    prev_scl = l_scl;
    prev_sda = l_sda;
  end

  int done_cnt = 0;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  // ---------------- transaction reference model + driver
  logic [7:0] model_rd = 8'h00;

  task automatic run_txn(input logic rw, input logic [7:0] ra, input logic [7:0] wd,
                         input logic [7:0] rb, input int nk, input int sk,
                         input bit extra_start, output int lat);
    int exp_ev[$];
    int slots, base, d0, n, exp_lat;
    bit nacked, stretched;
    logic [7:0] b;
    exp_ev.push_back(EV_S);
    slots = 1; nacked = 0; stretched = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) b = DEVW;
      else if (i == 1) b = ra;
      else if (!rw) b = wd;
      else begin b = DEVR; exp_ev.push_back(EV_S); slots++; end
      exp_ev.push_back(int'(b));
      slots += 9;
      if (i == sk) stretched = 1;
      if (i == nk) begin nacked = 1; break; end
    end
    if (rw && !nacked) begin exp_ev.push_back(257); slots += 9; end
    exp_ev.push_back(EV_P);
    slots++;
    exp_lat = slots * 4 * int'(CD) + (stretched ? STRETCH : 0);
    if (rw && !nacked) model_rd = rb;

    nack_idx = nk; stretch_idx = sk; slv_rd = rb;
    base = events.size(); d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.rw = rw; bus.regAddr = ra; bus.wrData = wd;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (n < 2000 && bus.done !== 1'b1) begin
      @(negedge clk);
      n++;
      bus.start = (extra_start && n == 10);
    end
    lat = n;
    check("latency", n, exp_lat);
    check("ackErr", {31'd0, bus.ackErr}, {31'd0, nacked});
    check("rdData", {24'd0, bus.rdData}, {24'd0, model_rd});
    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
    if (extra_start) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_width", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check("busy_after_done", {31'd0, bus.busy}, 32'd0);
    #1;
    check("done_pulses", done_cnt - d0, 1);
    check("ev_count", events.size() - base, exp_ev.size());
    for (int i = 0; i < exp_ev.size() && base + i < events.size(); i++)
      check($sformatf("ev%0d", i), events[base+i], exp_ev[i]);
    nack_idx = -1; stretch_idx = -1;
  endtask

  int lat, lat0, d0;

  initial begin
    bus.start = 1'b0; bus.rw = 1'b0; bus.regAddr = 8'h00; bus.wrData = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_scl",    {31'd0, bus.sclOut}, 32'd1);
    check("rst_sda",    {31'd0, bus.sdaOut}, 32'd1);
    check("rst_busy",   {31'd0, bus.busy},   32'd0);
    check("rst_done",   {31'd0, bus.done},   32'd0);
    check("rst_ackErr", {31'd0, bus.ackErr}, 32'd0);
    check("rst_rdData", {24'd0, bus.rdData}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(1'b0, 8'h02, 8'hA5, 8'h00, -1, -1, 1'b0, lat);
    run_txn(1'b1, 8'h05, 8'h00, 8'h3C, -1, -1, 1'b0, lat);
    run_txn(1'b0, 8'h11, 8'h22, 8'h00, 0, -1, 1'b0, lat);
    run_txn(1'b0, 8'h40, 8'h5A, 8'h00, -1, -1, 1'b1, lat);

    // Reset in the middle of the register-address byte.
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b0; bus.regAddr = 8'hC3; bus.wrData = 8'h99;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (13 * 4 * CD) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_scl",  {31'd0, bus.sclOut}, 32'd1);
    check("midrst_sda",  {31'd0, bus.sdaOut}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy},   32'd0);
    check("midrst_done", {31'd0, bus.done},   32'd0);
    rst = 1'b0;
    model_rd = 8'h00;
    repeat (20) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    run_txn(1'b0, 8'h02, 8'h5C, 8'h00, -1, -1, 1'b0, lat);

    for (int t = 0; t < 10; t++) begin
      int nk;
      nk = int'($urandom_range(0, 5));
      if (nk > 2) nk = -1;
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
              nk, -1, 1'($urandom_range(0, 1)), lat);
    end

`ifdef I2C_MASTER_STRETCH_EN
    run_txn(1'b0, 8'h07, 8'h81, 8'h00, -1, -1, 1'b0, lat0);
    run_txn(1'b0, 8'h07, 8'h81, 8'h00, -1, 2, 1'b0, lat);
    check("stretch_delta", lat - lat0, STRETCH);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
